// File: rtl/mmbmp_plot.sv
`default_nettype none
// ============================================================================
// Module      : mmbmp_plot
// Description : Pixel plot engine for a 1bpp 320x240 framebuffer. Turns
//               (x, y, op) requests into read-modify-write cycles (or a
//               direct byte write) on the framebuffer RAM port, using the
//               same address/bit mapping as the display scan-out.
// Revision    : 1.0 - initial release
// ============================================================================
module mmbmp_plot #(
  parameter int H_PIXELS   = 320,
  parameter int V_PIXELS   = 240,
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [8:0]  req_x,
  input  logic [7:0]  req_y,
  input  logic [1:0]  req_op,
  input  logic [7:0]  req_data,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  output logic        done,
  output logic        err
);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_READ  = 2'd1;
  localparam logic [1:0] c_ST_WAIT  = 2'd2;
  localparam logic [1:0] c_ST_WRITE = 2'd3;

  localparam logic [1:0] c_OP_CLR  = 2'b00;
  localparam logic [1:0] c_OP_SET  = 2'b01;
  localparam logic [1:0] c_OP_TGL  = 2'b10;
  localparam logic [1:0] c_OP_BYTE = 2'b11;

  // Limits widened by one bit so the parameter values themselves fit.
  localparam logic [9:0] c_H_LIMIT   = 10'(H_PIXELS);
  localparam logic [8:0] c_V_LIMIT   = 9'(V_PIXELS);
  // Counter value in the final WAIT cycle (RD_LATENCY is 1..3).
  localparam logic [1:0] c_WAIT_LAST = 2'(RD_LATENCY - 1);

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [1:0]  r_wait_cnt;
  logic [2:0]  r_bit;
  logic [1:0]  r_op;

  logic [15:0] r_mem_addr;
  logic        r_mem_rd;
  logic        r_mem_wr;
  logic [7:0]  r_mem_wdata;
  logic        r_done;
  logic        r_err;

  logic        w_xfer;
  logic        w_in_range;
  logic        w_wait_last;
  logic [7:0]  w_mask;
  logic [7:0]  w_modified;
  logic [15:0] w_addr_nxt;
  logic [7:0]  w_wdata_nxt;
  logic        w_rd_nxt;
  logic        w_wr_nxt;
  logic        w_err_nxt;

  assign req_ready   = (r_state == c_ST_IDLE);
  assign w_xfer      = req_valid && (r_state == c_ST_IDLE);
  assign w_in_range  = ({1'b0, req_x} < c_H_LIMIT) && ({1'b0, req_y} < c_V_LIMIT);
  assign w_wait_last = (r_wait_cnt == c_WAIT_LAST);
  // Bit 0 of a framebuffer byte is the leftmost pixel of its 8-pixel group.
  assign w_mask      = 8'b0000_0001 << r_bit;

  // Apply the latched bit operation to the byte returned by the RAM.
  always_comb begin
    w_modified = mem_rdata;
    case (r_op)
      c_OP_CLR: w_modified = mem_rdata & ~w_mask;
      c_OP_SET: w_modified = mem_rdata | w_mask;
      c_OP_TGL: w_modified = mem_rdata ^ w_mask;
      default:  w_modified = mem_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; out-of-range requests never leave IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_xfer && w_in_range) begin
          w_state_nxt = (req_op == c_OP_BYTE) ? c_ST_WRITE : c_ST_READ;
        end
      end
      c_ST_READ:  w_state_nxt = c_ST_WAIT;
      c_ST_WAIT:  if (w_wait_last) w_state_nxt = c_ST_WRITE;
      c_ST_WRITE: w_state_nxt = c_ST_IDLE;
      default:    w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Output logic: next-cycle values of the registered memory-side outputs.
  always_comb begin
    w_rd_nxt    = (w_state_nxt == c_ST_READ);
    w_wr_nxt    = (w_state_nxt == c_ST_WRITE);
    w_err_nxt   = w_xfer && !w_in_range;
    w_addr_nxt  = r_mem_addr;
    w_wdata_nxt = r_mem_wdata;
    if (w_xfer && w_in_range) begin
      w_addr_nxt = {2'b00, req_y, req_x[8:3]};
      if (req_op == c_OP_BYTE) begin
        w_wdata_nxt = req_data;
      end
    end else if ((r_state == c_ST_WAIT) && w_wait_last) begin
      // Read data is valid in the last WAIT cycle; capture the modified byte.
      w_wdata_nxt = w_modified;
    end
  end

  // Output registers, so nothing reaches the RAM port combinationally from req_*.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_addr  <= 16'h0000;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_wdata <= 8'h00;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_mem_addr  <= w_addr_nxt;
      r_mem_rd    <= w_rd_nxt;
      r_mem_wr    <= w_wr_nxt;
      r_mem_wdata <= w_wdata_nxt;
      r_done      <= w_wr_nxt;
      r_err       <= w_err_nxt;
    end
  end

  // Request latch and read-latency counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit      <= 3'd0;
      r_op       <= 2'b00;
      r_wait_cnt <= 2'd0;
    end else begin
      if (w_xfer && w_in_range) begin
        r_bit <= req_x[2:0];
        r_op  <= req_op;
      end
      if (r_state == c_ST_WAIT) begin
        r_wait_cnt <= r_wait_cnt + 2'd1;
      end else begin
        r_wait_cnt <= 2'd0;
      end
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_rd    = r_mem_rd;
  assign mem_wr    = r_mem_wr;
  assign mem_wdata = r_mem_wdata;
  assign done      = r_done;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mmbmp_plot.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mmbmp_plot
// Description : Directed self-checking bench for mmbmp_plot; one instance
//               with RD_LATENCY=1 and one with RD_LATENCY=3, each with a
//               behavioural framebuffer RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmbmp_plot;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        req_valid1 = 1'b0;
  logic        req_valid3 = 1'b0;
  logic [8:0]  req_x = '0;
  logic [7:0]  req_y = '0;
  logic [1:0]  req_op = '0;
  logic [7:0]  req_data = '0;

  logic        ready1, rd1, wr1, done1, err1;
  logic [15:0] addr1;
  logic [7:0]  rdata1, wdata1;
  logic        ready3, rd3, wr3, done3, err3;
  logic [15:0] addr3;
  logic [7:0]  rdata3, wdata3;

  int checks = 0;
  int errors = 0;

  // RAM preload port, shared by both RAM models
  logic        pl_en = 1'b0;
  logic [15:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;

  logic [7:0] mem1 [0:65535];
  logic [7:0] mem3 [0:65535];
  logic       v1 = 1'b0;
  logic [7:0] d1 = '0;
  logic [2:0] v3 = '0;
  logic [7:0] d3_0 = '0, d3_1 = '0, d3_2 = '0;
  int rd_cnt1 = 0, wr_cnt1 = 0, err_cnt1 = 0, wr_cnt3 = 0;

  mmbmp_plot #(.H_PIXELS(320), .V_PIXELS(240), .RD_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(ready1),
    .req_x(req_x), .req_y(req_y), .req_op(req_op), .req_data(req_data),
    .mem_addr(addr1), .mem_rd(rd1), .mem_rdata(rdata1), .mem_wr(wr1),
    .mem_wdata(wdata1), .done(done1), .err(err1)
  );

  mmbmp_plot #(.H_PIXELS(320), .V_PIXELS(240), .RD_LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(ready3),
    .req_x(req_x), .req_y(req_y), .req_op(req_op), .req_data(req_data),
    .mem_addr(addr3), .mem_rd(rd3), .mem_rdata(rdata3), .mem_wr(wr3),
    .mem_wdata(wdata3), .done(done3), .err(err3)
  );

  // RAM models: read data is valid only in the exact cycle RD_LATENCY after
  // mem_rd; at any other time the bus carries a junk pattern.
  always @(posedge clk) begin
    if (pl_en) mem1[pl_addr] <= pl_data;
    else if (wr1) mem1[addr1] <= wdata1;
    v1 <= rd1;
    d1 <= mem1[addr1];
    if (rd1)  rd_cnt1  <= rd_cnt1 + 1;
    if (wr1)  wr_cnt1  <= wr_cnt1 + 1;
    if (err1) err_cnt1 <= err_cnt1 + 1;
  end
  assign rdata1 = v1 ? d1 : 8'h5A;

  always @(posedge clk) begin
    if (pl_en) mem3[pl_addr] <= pl_data;
    else if (wr3) mem3[addr3] <= wdata3;
    v3   <= {v3[1:0], rd3};
    d3_0 <= mem3[addr3];
    d3_1 <= d3_0;
    d3_2 <= d3_1;
    if (wr3) wr_cnt3 <= wr_cnt3 + 1;
  end
  assign rdata3 = v3[2] ? d3_2 : 8'h5A;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    step();
    pl_en = 1'b0;
  endtask

  // Issue one request to the latency-1 instance and capture its write cycle.
  task automatic run_req1(input logic [8:0] x, input logic [7:0] y, input logic [1:0] op,
                          input logic [7:0] data, output logic [15:0] a,
                          output logic [7:0] w, output bit timeout);
    int n;
    req_x = x; req_y = y; req_op = op; req_data = data; req_valid1 = 1'b1;
    step();
    req_valid1 = 1'b0;
    n = 0;
    while (!wr1 && n < 20) begin step(); n++; end
    timeout = !wr1;
    a = addr1;
    w = wdata1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0h expected 1", ready1); end
    checks++; if ({rd1, wr1, done1, err1} !== 4'b0000) begin errors++; $display("FAIL reset_strobes: got %b expected 0000", {rd1, wr1, done1, err1}); end
    checks++; if (addr1 !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h expected 0000", addr1); end
    checks++; if (wdata1 !== 8'h00) begin errors++; $display("FAIL reset_wdata: got %h expected 00", wdata1); end
    checks++; if (ready3 !== 1'b1 || wr3 !== 1'b0) begin errors++; $display("FAIL reset_dut3: got ready=%0h wr=%0h expected 1/0", ready3, wr3); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_set_pixel();
    preload(16'h0080, 8'h00);
    req_x = 9'd5; req_y = 8'd2; req_op = 2'b01; req_data = 8'h00; req_valid1 = 1'b1;
    checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL set_ready_c0: got %0h expected 1", ready1); end
    step();  // cycle 1
    req_valid1 = 1'b0;
    checks++; if (rd1 !== 1'b1 || addr1 !== 16'h0080) begin errors++; $display("FAIL set_read_c1: got rd=%0h addr=%h expected 1/0080", rd1, addr1); end
    checks++; if (ready1 !== 1'b0 || wr1 !== 1'b0) begin errors++; $display("FAIL set_busy_c1: got ready=%0h wr=%0h expected 0/0", ready1, wr1); end
    step();  // cycle 2
    checks++; if (rd1 !== 1'b0 || wr1 !== 1'b0 || ready1 !== 1'b0) begin errors++; $display("FAIL set_wait_c2: got rd=%0h wr=%0h ready=%0h expected 0/0/0", rd1, wr1, ready1); end
    step();  // cycle 3
    checks++; if (wr1 !== 1'b1 || done1 !== 1'b1 || ready1 !== 1'b0) begin errors++; $display("FAIL set_write_c3: got wr=%0h done=%0h ready=%0h expected 1/1/0", wr1, done1, ready1); end
    checks++; if (wdata1 !== 8'h20 || addr1 !== 16'h0080) begin errors++; $display("FAIL set_wdata_c3: got %h@%h expected 20@0080", wdata1, addr1); end
    step();  // cycle 4
    checks++; if (ready1 !== 1'b1 || wr1 !== 1'b0 || done1 !== 1'b0) begin errors++; $display("FAIL set_idle_c4: got ready=%0h wr=%0h done=%0h expected 1/0/0", ready1, wr1, done1); end
    checks++; if (mem1[16'h0080] !== 8'h20) begin errors++; $display("FAIL set_mem: got %h expected 20", mem1[16'h0080]); end
  endtask

  task automatic test_boundary_clear_toggle();
    logic [15:0] a; logic [7:0] w; bit to;
    preload(16'h3BE7, 8'hFF);
    run_req1(9'd319, 8'd239, 2'b00, 8'h00, a, w, to);
    checks++; if (to) begin errors++; $display("FAIL clear_timeout: got no mem_wr expected mem_wr"); end
    checks++; if (a !== 16'h3BE7 || w !== 8'h7F) begin errors++; $display("FAIL clear_write: got %h@%h expected 7F@3BE7", w, a); end
    run_req1(9'd319, 8'd239, 2'b10, 8'h00, a, w, to);
    checks++; if (to) begin errors++; $display("FAIL toggle_timeout: got no mem_wr expected mem_wr"); end
    checks++; if (a !== 16'h3BE7 || w !== 8'hFF) begin errors++; $display("FAIL toggle_write: got %h@%h expected FF@3BE7", w, a); end
    checks++; if (mem1[16'h3BE7] !== 8'hFF) begin errors++; $display("FAIL toggle_mem: got %h expected FF", mem1[16'h3BE7]); end
  endtask

  task automatic test_out_of_range();
    int rc, wc, ec;
    rc = rd_cnt1; wc = wr_cnt1; ec = err_cnt1;
    req_x = 9'd320; req_y = 8'd0; req_op = 2'b01; req_valid1 = 1'b1;
    step();
    req_valid1 = 1'b0;
    checks++; if (err1 !== 1'b1 || ready1 !== 1'b1) begin errors++; $display("FAIL oor_x_err: got err=%0h ready=%0h expected 1/1", err1, ready1); end
    step();
    checks++; if (err1 !== 1'b0 || ready1 !== 1'b1) begin errors++; $display("FAIL oor_x_pulse: got err=%0h ready=%0h expected 0/1", err1, ready1); end
    req_x = 9'd0; req_y = 8'd240; req_op = 2'b11; req_valid1 = 1'b1;
    step();
    req_valid1 = 1'b0;
    checks++; if (err1 !== 1'b1) begin errors++; $display("FAIL oor_y_err: got %0h expected 1", err1); end
    repeat (3) step();
    checks++; if (rd_cnt1 != rc || wr_cnt1 != wc) begin errors++; $display("FAIL oor_no_access: got rd=%0d wr=%0d expected 0/0", rd_cnt1 - rc, wr_cnt1 - wc); end
    checks++; if (err_cnt1 != ec + 2) begin errors++; $display("FAIL oor_err_count: got %0d expected 2", err_cnt1 - ec); end
  endtask

  task automatic test_byte_write();
    int rc;
    rc = rd_cnt1;
    req_x = 9'd8; req_y = 8'd1; req_op = 2'b11; req_data = 8'hA5; req_valid1 = 1'b1;
    step();
    req_valid1 = 1'b0;
    checks++; if (wr1 !== 1'b1 || done1 !== 1'b1 || rd1 !== 1'b0) begin errors++; $display("FAIL byte_strobes: got wr=%0h done=%0h rd=%0h expected 1/1/0", wr1, done1, rd1); end
    checks++; if (addr1 !== 16'h0041 || wdata1 !== 8'hA5) begin errors++; $display("FAIL byte_write: got %h@%h expected A5@0041", wdata1, addr1); end
    checks++; if (ready1 !== 1'b0) begin errors++; $display("FAIL byte_busy: got %0h expected 0", ready1); end
    step();
    checks++; if (ready1 !== 1'b1 || wr1 !== 1'b0) begin errors++; $display("FAIL byte_idle: got ready=%0h wr=%0h expected 1/0", ready1, wr1); end
    checks++; if (mem1[16'h0041] !== 8'hA5 || rd_cnt1 != rc) begin errors++; $display("FAIL byte_mem: got %h reads=%0d expected A5/0", mem1[16'h0041], rd_cnt1 - rc); end
  endtask

  task automatic test_back_to_back();
    int n;
    preload(16'h0000, 8'h00);
    req_x = 9'd0; req_y = 8'd0; req_op = 2'b01; req_valid1 = 1'b1;
    step();
    req_x = 9'd1;  // request held valid; second pixel presented immediately
    checks++; if (rd1 !== 1'b1 || addr1 !== 16'h0000) begin errors++; $display("FAIL b2b_read1: got rd=%0h addr=%h expected 1/0000", rd1, addr1); end
    n = 0;
    while (!wr1 && n < 10) begin step(); n++; end
    checks++; if (wr1 !== 1'b1 || wdata1 !== 8'h01) begin errors++; $display("FAIL b2b_write1: got wr=%0h wdata=%h expected 1/01", wr1, wdata1); end
    step();
    checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_wr: got %0h expected 1", ready1); end
    step();
    req_valid1 = 1'b0;
    checks++; if (rd1 !== 1'b1 || addr1 !== 16'h0000) begin errors++; $display("FAIL b2b_read2: got rd=%0h addr=%h expected 1/0000", rd1, addr1); end
    n = 0;
    while (!wr1 && n < 10) begin step(); n++; end
    checks++; if (wr1 !== 1'b1 || wdata1 !== 8'h03) begin errors++; $display("FAIL b2b_write2: got wr=%0h wdata=%h expected 1/03", wr1, wdata1); end
    step();
    checks++; if (mem1[16'h0000] !== 8'h03) begin errors++; $display("FAIL b2b_mem: got %h expected 03", mem1[16'h0000]); end
  endtask

  task automatic test_reset_during_wait();
    int wc;
    preload(16'h0103, 8'h0F);
    wc = wr_cnt1;
    req_x = 9'd24; req_y = 8'd4; req_op = 2'b01; req_valid1 = 1'b1;
    step();  // cycle 1: READ
    req_valid1 = 1'b0;
    checks++; if (rd1 !== 1'b1 || addr1 !== 16'h0103) begin errors++; $display("FAIL rstw_read: got rd=%0h addr=%h expected 1/0103", rd1, addr1); end
    step();  // cycle 2: WAIT
    rst_n = 1'b0;
    #1;
    checks++; if ({rd1, wr1, done1} !== 3'b000 || ready1 !== 1'b1) begin errors++; $display("FAIL rstw_abort: got rd/wr/done=%b ready=%0h expected 000/1", {rd1, wr1, done1}, ready1); end
    step(); step();
    rst_n = 1'b1;
    repeat (4) step();
    checks++; if (wr_cnt1 != wc || mem1[16'h0103] !== 8'h0F) begin errors++; $display("FAIL rstw_no_write: got writes=%0d mem=%h expected 0/0F", wr_cnt1 - wc, mem1[16'h0103]); end
    checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL rstw_ready: got %0h expected 1", ready1); end
  endtask

  task automatic test_latency3();
    int wc;
    preload(16'h0080, 8'h01);
    req_x = 9'd5; req_y = 8'd2; req_op = 2'b01; req_valid3 = 1'b1;
    step();  // cycle 1
    req_valid3 = 1'b0;
    checks++; if (rd3 !== 1'b1 || addr3 !== 16'h0080) begin errors++; $display("FAIL lat3_read: got rd=%0h addr=%h expected 1/0080", rd3, addr3); end
    for (int i = 0; i < 3; i++) begin
      step();  // cycles 2..4
      checks++; if (wr3 !== 1'b0 || ready3 !== 1'b0) begin errors++; $display("FAIL lat3_wait%0d: got wr=%0h ready=%0h expected 0/0", i, wr3, ready3); end
    end
    step();  // cycle 5
    checks++; if (wr3 !== 1'b1 || done3 !== 1'b1 || wdata3 !== 8'h21) begin errors++; $display("FAIL lat3_write: got wr=%0h done=%0h wdata=%h expected 1/1/21", wr3, done3, wdata3); end
    step();
    checks++; if (mem3[16'h0080] !== 8'h21 || ready3 !== 1'b1) begin errors++; $display("FAIL lat3_mem: got %h ready=%0h expected 21/1", mem3[16'h0080], ready3); end
    // abort during the middle WAIT cycle
    preload(16'h0103, 8'h0F);
    wc = wr_cnt3;
    req_x = 9'd24; req_y = 8'd4; req_op = 2'b10; req_valid3 = 1'b1;
    step();
    req_valid3 = 1'b0;
    step(); step();  // cycle 3: WAIT
    rst_n = 1'b0;
    #1;
    checks++; if ({rd3, wr3, done3} !== 3'b000 || ready3 !== 1'b1) begin errors++; $display("FAIL lat3_abort: got rd/wr/done=%b ready=%0h expected 000/1", {rd3, wr3, done3}, ready3); end
    step();
    rst_n = 1'b1;
    repeat (6) step();
    checks++; if (wr_cnt3 != wc || mem3[16'h0103] !== 8'h0F) begin errors++; $display("FAIL lat3_no_write: got writes=%0d mem=%h expected 0/0F", wr_cnt3 - wc, mem3[16'h0103]); end
  endtask

  initial begin
    test_reset();
    test_set_pixel();
    test_boundary_clear_toggle();
    test_out_of_range();
    test_byte_write();
    test_back_to_back();
    test_reset_during_wait();
    test_latency3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish within 200us");
    $fatal(1);
  end

endmodule
`default_nettype wire
